// File: rtl/serial_adder_if.sv
// serial_adder_if -- request/result bundle for the bit-serial adder.
//   master : drives Start, Mode, A, B, C; observes Busy, Done, Sum, Carry, Overflow
//   slave  : the adder side of the same signals
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;

  modport master (
    output Start, Mode, A, B, C,
    input  Busy, Done, Sum, Carry, Overflow
  );

  modport slave (
    input  Start, Mode, A, B, C,
    output Busy, Done, Sum, Carry, Overflow
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial add/subtract, LSB first, one bit per clock.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_if.slave
//          Start/Mode/A/B/C sampled when not busy (IDLE or DONE)
//          Busy high during RUN, Done one-cycle pulse with Sum/Carry/Overflow
//          Mode=1 computes A - B - C; Carry is then the no-borrow flag.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | one operand bit per cycle through the 1-bit full adder
// DONE  | result presented for one cycle; Start here chains the next op
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shift_q;
  logic             mode_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             a_bit;
  logic             b_bit;
  logic             s_bit;
  logic             c_out;
  logic [WIDTH-1:0] shift_nxt;

  // Single full adder; subtraction inverts B and the borrow-in (loaded
  // into carry_q at accept), giving A + ~B + ~C.
  always_comb begin
    a_bit     = a_q[cnt_q];
    b_bit     = b_q[cnt_q] ^ mode_q;
    s_bit     = a_bit ^ b_bit ^ carry_q;
    c_out     = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    shift_nxt = {s_bit, shift_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      shift_q      <= '0;
      mode_q       <= 1'b0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
      bus.Sum      <= '0;
      bus.Carry    <= 1'b0;
      bus.Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.Done <= 1'b0;
          if (bus.Start) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            mode_q   <= bus.Mode;
            carry_q  <= bus.C ^ bus.Mode;
            cnt_q    <= '0;
            bus.Busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry_q <= c_out;
          shift_q <= shift_nxt;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // carry_q here is the carry into the MSB
            bus.Sum      <= shift_nxt;
            bus.Carry    <= c_out;
            bus.Overflow <= carry_q ^ c_out;
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b1;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst4 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    int         at;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every Done against the oldest expected result.
  logic prev_done8 = 1'b0;
  logic prev_done4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (if8.Done === 1'b1) begin
      check("done8_width", {63'd0, prev_done8}, 64'd0);
      check("busy8_at_done", {63'd0, if8.Busy}, 64'd0);
      if (q8.size() == 0) begin
        check("unexpected_done8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        check("sum8", {56'd0, if8.Sum}, {56'd0, e.sum});
        check("carry8", {63'd0, if8.Carry}, {63'd0, e.carry});
        check("ovf8", {63'd0, if8.Overflow}, {63'd0, e.ovf});
        check("latency8", 64'(cyc), 64'(e.at));
      end
    end
    if (if4.Done === 1'b1) begin
      check("done4_width", {63'd0, prev_done4}, 64'd0);
      if (q4.size() == 0) begin
        check("unexpected_done4", 64'd1, 64'd0);
      end else begin
        e = q4.pop_front();
        check("sum4", {60'd0, if4.Sum}, {56'd0, e.sum});
        check("carry4", {63'd0, if4.Carry}, {63'd0, e.carry});
        check("ovf4", {63'd0, if4.Overflow}, {63'd0, e.ovf});
        check("latency4", 64'(cyc), 64'(e.at));
      end
    end
    prev_done8 = if8.Done;
    prev_done4 = if4.Done;
  end

  task automatic push8(input logic [7:0] s, input logic c, input logic o, input int at);
    exp_t e;
    e.sum = s; e.carry = c; e.ovf = o; e.at = at;
    q8.push_back(e);
  endtask

  // One isolated operation on the 8-bit adder.
  task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] s, input logic co, input logic o);
    @(negedge clk);
    if8.Mode = m; if8.A = a; if8.B = b; if8.C = c; if8.Start = 1'b1;
    push8(s, co, o, cyc + 1 + 8);
    @(posedge clk);
    #1 if8.Start = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       o;
  } vec_t;

  vec_t vecs[7];
  vec_t chain[3];

  initial begin
    int k0;
    int budget;
    logic [3:0] a4, b4;
    logic       c4;
    logic [4:0] full4;

    // Directed vectors, expected values worked by hand.
    vecs[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    chain[0] = '{1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    chain[1] = '{1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    chain[2] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};

    if8.Start = 1'b0; if8.Mode = 1'b0; if8.A = '0; if8.B = '0; if8.C = 1'b0;
    if4.Start = 1'b0; if4.Mode = 1'b0; if4.A = '0; if4.B = '0; if4.C = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, if8.Busy}, 64'd0);
    check("rst_done", {63'd0, if8.Done}, 64'd0);
    check("rst_sum", {56'd0, if8.Sum}, 64'd0);
    check("rst_carry", {63'd0, if8.Carry}, 64'd0);
    check("rst_ovf", {63'd0, if8.Overflow}, 64'd0);
    check("rst4_busy", {63'd0, if4.Busy}, 64'd0);

    foreach (vecs[i]) op8(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].o);

    // Start pulsed with other operands during RUN must be ignored.
    @(negedge clk);
    if8.Mode = 1'b0; if8.A = 8'h12; if8.B = 8'h34; if8.C = 1'b0; if8.Start = 1'b1;
    push8(8'h46, 1'b0, 1'b0, cyc + 1 + 8);
    @(posedge clk);
    #1 if8.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_in_run", {63'd0, if8.Busy}, 64'd1);
    if8.Mode = 1'b1; if8.A = 8'h55; if8.B = 8'hAA; if8.C = 1'b1; if8.Start = 1'b1;
    @(negedge clk);
    if8.A = 8'hC3; if8.B = 8'h3C;
    @(negedge clk);
    if8.Start = 1'b0;
    repeat (10) @(posedge clk);

    // Start held high: chained ops every 9 cycles.
    @(negedge clk);
    k0 = cyc + 1;
    foreach (chain[i]) begin
      if8.Mode = chain[i].m; if8.A = chain[i].a; if8.B = chain[i].b; if8.C = chain[i].c;
      if8.Start = 1'b1;
      push8(chain[i].s, chain[i].co, chain[i].o, k0 + i * 9 + 8);
      if (i == 0) @(posedge clk);
      else repeat (9) @(posedge clk);
      #1;
    end
    if8.Start = 1'b0;
    @(negedge clk);
    check("busy_chain_run", {63'd0, if8.Busy}, 64'd1);
    repeat (10) @(posedge clk);

    // Reset during the 3rd RUN cycle aborts with no Done.
    @(negedge clk);
    if8.Mode = 1'b0; if8.A = 8'h33; if8.B = 8'h44; if8.C = 1'b0; if8.Start = 1'b1;
    @(posedge clk);
    #1 if8.Start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1 rst8 = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, if8.Busy}, 64'd0);
    check("abort_done", {63'd0, if8.Done}, 64'd0);
    check("abort_sum", {56'd0, if8.Sum}, 64'd0);
    check("abort_carry", {63'd0, if8.Carry}, 64'd0);
    check("abort_ovf", {63'd0, if8.Overflow}, 64'd0);
    repeat (10) @(posedge clk);

    // Reset wins over a simultaneous Start.
    @(negedge clk);
    if8.Mode = 1'b0; if8.A = 8'h01; if8.B = 8'h01; if8.C = 1'b0; if8.Start = 1'b1;
    rst8 = 1'b1;
    @(posedge clk);
    #1 rst8 = 1'b0; if8.Start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", {63'd0, if8.Busy}, 64'd0);
    repeat (12) @(posedge clk);

    // WIDTH=4 exhaustive add with Start held high; operands change during RUN.
    @(negedge clk);
    k0 = cyc + 1;
    for (int i = 0; i < 512; i++) begin
      {c4, b4, a4} = 9'(i);
      if4.Mode = 1'b0; if4.A = a4; if4.B = b4; if4.C = c4; if4.Start = 1'b1;
      full4 = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
      begin
        exp_t e;
        e.sum   = {4'd0, full4[3:0]};
        e.carry = full4[4];
        e.ovf   = (a4[3] == b4[3]) && (full4[3] != a4[3]);
        e.at    = k0 + i * 5 + 4;
        q4.push_back(e);
      end
      if (i == 0) @(posedge clk);
      else repeat (5) @(posedge clk);
      #1;
    end
    if4.Start = 1'b0;

    budget = 0;
    while ((q8.size() != 0 || q4.size() != 0) && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    check("pending8", 64'(q8.size()), 64'd0);
    check("pending4", 64'(q4.size()), 64'd0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port Start  input  1  request; accepted only when not Busy.
REQ-005 SHALL have port Mode  input  1  0 = add, 1 = subtract; sampled with Start.
REQ-006 SHALL have port A  input  WIDTH  operand A; sampled with Start.
REQ-007 SHALL have port B  input  WIDTH  operand B; sampled with Start.
REQ-008 SHALL have port C  input  1  carry-in (add) / borrow-in (subtract); sampled with Start.
REQ-009 SHALL have port Busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port Done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port Sum  output  WIDTH  result.
REQ-012 SHALL have port Carry  output  1  carry-out (add) / no-borrow flag (subtract).
REQ-013 SHALL have port Overflow  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL compute the result bit-serially, LSB first, one bit per cycle, using a single 1-bit full-adder datapath plus a registered carry.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE -> RUN on Start=1.
- RUN -> DONE after the WIDTH-th bit.
- DONE -> RUN on Start=1, else DONE -> IDLE.
REQ-016 SHALL, on the edge accepting Start (state IDLE or DONE):
- latch A, B, Mode.
- load the carry register with C when Mode=0, ~C when Mode=1.
- clear the bit counter (width clog2(WIDTH)).
- set Busy=1.
REQ-017 SHALL, in subtract mode, use ~B as the second addend, so the result is A - B - C mod 2^WIDTH.
REQ-018 SHALL process bit i on the i-th RUN edge, i = 0..WIDTH-1; latency is exactly WIDTH cycles: Start sampled at edge k -> Done=1 and Busy=0 in the cycle following edge k+WIDTH.
REQ-019 SHALL update Sum, Carry and Overflow only on the edge entering DONE, and hold them until the next such edge or reset; intermediate bits stay in an internal shift register.
REQ-020 SHALL set Carry to the final carry-out, and Overflow to (carry into MSB) XOR (carry out of MSB).
REQ-021 SHALL ignore Start while in RUN; latched operands are unaffected by input changes during RUN.
REQ-022 SHALL accept Start in the DONE cycle, giving back-to-back operations with one Done cycle between them; Busy is then low only in the DONE cycle.
REQ-023 SHALL assert Done for exactly one cycle per accepted Start that completes.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, go to IDLE and drive Busy=0, Done=0, Sum=0, Carry=0, Overflow=0; it SHALL also clear the internal carry, counter and shift registers.
REQ-025 SHALL give rst priority over Start in the same cycle; the Start is dropped.
REQ-026 SHALL, when reset occurs mid-RUN, abort the operation with no Done pulse and no result update.

Verification
REQ-027 SHALL pass, at WIDTH=8, add 0x0F+0x01, C=0:
- Done exactly 8 cycles after the Start edge.
- Sum=0x10, Carry=0, Overflow=0.
REQ-028 SHALL pass, at WIDTH=8, add 0xFF+0x01, C=0 -> Sum=0x00, Carry=1, Overflow=0; add 0x7F+0x00, C=1 -> Sum=0x80, Carry=0, Overflow=1.
REQ-029 SHALL pass, at WIDTH=8, subtract 0x05-0x07, C=0 -> Sum=0xFE, Carry=0, Overflow=0; subtract 0x80-0x01, C=0 -> Sum=0x7F, Carry=1, Overflow=1.
REQ-030 SHALL pass Start pulsed with new operands during RUN: ignored, first result unchanged, exactly one Done.
REQ-031 SHALL pass rst asserted on the 3rd RUN cycle: next cycle Busy=0, all outputs 0, no Done for 10 following cycles.
REQ-032 SHALL pass Start held high continuously: results every 9 cycles, each Done one cycle wide, and all WIDTH=4 add cases exhaustive (512 combos incl. C) matching A+B+C.
